usb_rx_ctrl: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 17 +
 rtl/usb_stuff_detect.sv | 44 ++++
 rtl/usb_rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RCV,
        ERR,
        EOPW,
        EOPW_ERR
    } rx_state_t;

    localparam logic [7:0] SYNC_PATTERN    = 8'h80;
    localparam int         USB_STUFF_LIMIT = 6;
    localparam int         BYTE_BITS       = 8;

endpackage

// File: rtl/usb_stuff_detect.sv
// Tracks consecutive 1s in the data field and flags the bit that must be a stuffed 0.
// Macro USB_RX_STUFF_ERR_EN: when defined, a 1 in a stuffed position raises o_viol.
module usb_stuff_detect
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_strobe,
    input  logic i_bit,
    output logic o_skip,
    output logic o_viol
);

    localparam int CW = $clog2(STUFF_LIMIT + 1);

    logic [CW-1:0] r_ones_cnt;

    assign o_skip = (r_ones_cnt == CW'(STUFF_LIMIT));

`ifdef USB_RX_STUFF_ERR_EN
    assign o_viol = o_skip & i_bit;
`else
    assign o_viol = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones_cnt <= '0;
        end else if (i_clr) begin
            r_ones_cnt <= '0;
        end else if (i_strobe) begin
            // The stuffed bit itself restarts the run regardless of its value.
            if (o_skip || !i_bit) begin
                r_ones_cnt <= '0;
            end else begin
                r_ones_cnt <= r_ones_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive sequencer: SYNC check, destuffing, LSB-first byte assembly, EOP tracking.
// Macro USB_RX_STUFF_ERR_EN (in usb_stuff_detect) turns a 1 in a stuffed position into a packet error.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_PATTERN,
    parameter int         MAX_BYTES   = 64,
    parameter int         STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               d_orig,
    input  logic                               d_edge,
    input  logic                               shift_enable,
    input  logic                               eop,
    output logic [7:0]                         rx_data,
    output logic                               w_enable,
    output logic                               rcving,
    output logic                               r_error,
    output logic                               packet_done,
    output logic [$clog2(MAX_BYTES+1)-1:0]     byte_count,
    output logic [2:0]                         dbg_state
);

    localparam int BC_W   = $clog2(MAX_BYTES + 1);
    localparam int BIT_CW = $clog2(BYTE_BITS);

    rx_state_t         r_state;
    rx_state_t         w_next_state;
    // Seven most recent bits; the eighth comes straight from d_orig on completion.
    logic [6:0]        r_part;
    logic [BIT_CW-1:0] r_bit_cnt;
    logic [7:0]        w_assembled;
    logic              w_strobe;
    logic              w_eop_strobe;
    logic              w_last_bit;
    logic              w_shift;
    logic              w_write;
    logic              w_pkt_start;
    logic              w_done;
    logic              w_stuff_strobe;
    logic              w_skip;
    logic              w_viol;

    assign w_strobe     = shift_enable & ~eop;
    assign w_eop_strobe = shift_enable & eop;
    assign w_assembled  = {d_orig, r_part};
    assign w_last_bit   = (r_bit_cnt == BIT_CW'(BYTE_BITS - 1));
    assign rcving       = (r_state != IDLE);
    assign dbg_state    = r_state;

    usb_stuff_detect #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_stuff (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_pkt_start),
        .i_strobe (w_stuff_strobe),
        .i_bit    (d_orig),
        .o_skip   (w_skip),
        .o_viol   (w_viol)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_shift        = 1'b0;
        w_write        = 1'b0;
        w_pkt_start    = 1'b0;
        w_done         = 1'b0;
        w_stuff_strobe = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_edge) begin
                    w_next_state = SYNC;
                    w_pkt_start  = 1'b1;
                end
            end
            SYNC: begin
                if (w_eop_strobe) begin
                    w_next_state = ERR;
                end else if (w_strobe) begin
                    w_shift = 1'b1;
                    if (w_last_bit) w_next_state = (w_assembled == SYNC_BYTE) ? RCV : ERR;
                end
            end
            RCV: begin
                if (w_eop_strobe) begin
                    w_next_state = (r_bit_cnt == '0) ? EOPW : ERR;
                end else if (w_strobe) begin
                    w_stuff_strobe = 1'b1;
                    if (w_skip) begin
                        if (w_viol) w_next_state = ERR;
                    end else begin
                        w_shift = 1'b1;
                        if (w_last_bit) begin
                            if (byte_count == BC_W'(MAX_BYTES)) w_next_state = ERR;
                            else                                  w_write      = 1'b1;
                        end
                    end
                end
            end
            ERR: begin
                if (w_eop_strobe) w_next_state = EOPW_ERR;
            end
            EOPW: begin
                if (w_strobe) begin
                    w_next_state = IDLE;
                    w_done       = 1'b1;
                end
            end
            EOPW_ERR: begin
                if (w_strobe) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= 8'h00;
            w_enable    <= 1'b0;
            r_error     <= 1'b0;
            packet_done <= 1'b0;
            byte_count  <= '0;
            r_part      <= '0;
            r_bit_cnt   <= '0;
        end else begin
            w_enable    <= w_write;
            packet_done <= w_done;
            if (w_pkt_start) begin
                r_error    <= 1'b0;
                byte_count <= '0;
                r_part     <= '0;
                r_bit_cnt  <= '0;
            end else begin
                if (w_next_state == ERR) r_error <= 1'b1;
                if (w_shift) begin
                    r_part    <= w_assembled[7:1];
                    r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                end
                if (w_write) begin
                    rx_data    <= w_assembled;
                    byte_count <= byte_count + BC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl with a written-byte scoreboard and a bench-side bit stuffer.
module tb_usb_rx_ctrl;
    import usb_rx_pkg::*;

    localparam int MAXB = 4;
    localparam int BCW  = $clog2(MAXB + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           d_orig;
    logic           d_edge;
    logic           shift_enable;
    logic           eop;
    logic [7:0]     rx_data;
    logic           w_enable;
    logic           rcving;
    logic           r_error;
    logic           packet_done;
    logic [BCW-1:0] byte_count;
    logic [2:0]     dbg_state;

    always #5 clk = ~clk;

    usb_rx_ctrl #(
        .MAX_BYTES (MAXB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_orig       (d_orig),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .eop          (eop),
        .rx_data      (rx_data),
        .w_enable     (w_enable),
        .rcving       (rcving),
        .r_error      (r_error),
        .packet_done  (packet_done),
        .byte_count   (byte_count),
        .dbg_state    (dbg_state)
    );

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         pd_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    int         tx_ones = 0;
    int         pd0;

    always @(negedge clk) begin
        if (w_enable)    got_q.push_back(rx_data);
        if (packet_done) pd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_bit(input logic b, input logic e);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        d_orig       = b;
        eop          = e;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        eop          = 1'b0;
        d_orig       = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
    endtask

    task automatic pkt_start(input logic [7:0] sync_val);
        @(negedge clk);
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        send_raw(sync_val);
        tx_ones = 0;
    endtask

    // Data byte on the wire, LSB first, with a 0 inserted after every run of six 1s.
    task automatic send_byte(input string tag, input logic [7:0] v, input logic expect_write);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], 1'b0);
            tx_ones = v[i] ? tx_ones + 1 : 0;
            if (i == 7) check({tag, "_wen"}, w_enable, expect_write);
            if (tx_ones == 6) begin
                send_bit(1'b0, 1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; d_orig = 1'b0; d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_wen", w_enable, 1'b0);
        check("rst_rcving", rcving, 1'b0);
        check("rst_error", r_error, 1'b0);
        check("rst_pdone", packet_done, 1'b0);
        check("rst_count", byte_count, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good packet
        pd0 = pd_cnt;
        @(negedge clk);
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        check("good_rcving", rcving, 1'b1);
        send_raw(8'h80);
        tx_ones = 0;
        check("good_state_rcv", dbg_state, RCV);
        exp_q.push_back(8'hA5); send_byte("good_a5", 8'hA5, 1'b1);
        exp_q.push_back(8'h3C); send_byte("good_3c", 8'h3C, 1'b1);
        check("good_count", byte_count, 2);
        send_eop();
        check("good_pdone", pd_cnt - pd0, 1);
        check("good_error", r_error, 1'b0);
        check("good_idle", rcving, 1'b0);
        drain("good");

        // Bad sync, then a good packet clears the sticky error
        pd0 = pd_cnt;
        pkt_start(8'hC0);
        check("badsync_error", r_error, 1'b1);
        check("badsync_state", dbg_state, ERR);
        send_eop();
        check("badsync_pdone", pd_cnt - pd0, 0);
        drain("badsync");
        pd0 = pd_cnt;
        @(negedge clk);
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        check("resync_error_clr", r_error, 1'b0);
        send_raw(8'h80);
        tx_ones = 0;
        exp_q.push_back(8'h12); send_byte("resync_12", 8'h12, 1'b1);
        send_eop();
        check("resync_pdone", pd_cnt - pd0, 1);
        drain("resync");

        // Stuffed 0 is dropped
        pd0 = pd_cnt;
        pkt_start(8'h80);
        exp_q.push_back(8'hFF); send_byte("stuff_ff", 8'hFF, 1'b1);
        send_eop();
        check("stuff_error", r_error, 1'b0);
        check("stuff_pdone", pd_cnt - pd0, 1);
        drain("stuff");

        // A 1 in the stuffed position
        pd0 = pd_cnt;
        pkt_start(8'h80);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
`ifdef USB_RX_STUFF_ERR_EN
        check("stuffviol_error", r_error, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_eop();
        check("stuffviol_pdone", pd_cnt - pd0, 0);
`else
        exp_q.push_back(8'hFF);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("stuffone_wen", w_enable, 1'b1);
        send_eop();
        check("stuffone_error", r_error, 1'b0);
        check("stuffone_pdone", pd_cnt - pd0, 1);
`endif
        drain("stuffone");

        // Early EOP after four data bits
        pd0 = pd_cnt;
        pkt_start(8'h80);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_eop();
        check("early_error", r_error, 1'b1);
        check("early_state", dbg_state, IDLE);
        check("early_pdone", pd_cnt - pd0, 0);
        drain("early");

        // Overflow: MAXB bytes accepted, the next one errors without a write
        pd0 = pd_cnt;
        pkt_start(8'h80);
        for (int i = 0; i < MAXB; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte("ovf_byte", b, 1'b1);
        end
        check("ovf_count_full", byte_count, MAXB);
        send_byte("ovf_extra", 8'h77, 1'b0);
        check("ovf_error", r_error, 1'b1);
        check("ovf_count_sat", byte_count, MAXB);
        send_eop();
        check("ovf_pdone", pd_cnt - pd0, 0);
        drain("ovf");

        // Reset in the middle of a byte
        pd0 = pd_cnt;
        pkt_start(8'h80);
        exp_q.push_back(8'h5A); send_byte("pre_rst", 8'h5A, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_wen", w_enable, 1'b0);
        check("midrst_rcving", rcving, 1'b0);
        check("midrst_error", r_error, 1'b0);
        check("midrst_count", byte_count, 0);
        check("midrst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_pdone", pd_cnt - pd0, 0);
        drain("midrst");

        // Random packet after reset
        pd0 = pd_cnt;
        pkt_start(8'h80);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte("rand_byte", b, 1'b1);
        end
        check("rand_count", byte_count, 3);
        send_eop();
        check("rand_error", r_error, 1'b0);
        check("rand_pdone", pd_cnt - pd0, 1);
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
